bilat_window_gen: RTL
=====================

// Module: bilat_window_gen
// PURPOSE
//   Parametrised raster-stream 3x3 window generator. Front end of the next-generation bilateral filter.
//   - Accepts one signed pixel per cycle, raster order, IMG_W x IMG_H frame.
//   - Emits one full 3x3 neighbourhood per centre pixel, with border padding.
//   - Reports the raster address of each centre. Self-flushes the last rows after the frame ends.
// PARAMETERS
//   DATA_W    9    pixel width, two's complement
//   IMG_W     256  frame width in pixels (>=2)
//   IMG_H     256  frame height in pixels (>=2)
//   PAD_MODE  1    border mode: 0 = zero pad, 1 = replicate nearest edge pixel
//   ADDR_W    16   address width; must satisfy 2**ADDR_W >= IMG_W*IMG_H
// PORTS
//   clk        in   1         single clock, rising edge
//   rst        in   1         asynchronous, active-low reset
//   in_valid   in   1         in_data valid; accepted only when in_ready=1
//   in_ready   out  1         block can accept a pixel this cycle
//   in_data    in   DATA_W    input pixel, signed
//   in_addr    out  ADDR_W    raster index of the next pixel to be accepted
//   out_valid  out  1         out_win / out_addr valid, one-cycle strobe per centre
//   out_win    out  9*DATA_W  window; w[k] = out_win[k*DATA_W +: DATA_W]
//                             k=3*dr+dc, dr,dc in 0..2 map to row offsets -1..+1
//   out_addr   out  ADDR_W    raster index of the window centre (r*IMG_W+c)
//   frame_done out  1         one-cycle pulse coincident with the last out_valid of a frame
// BEHAVIOUR
//   Reset (rst=0, immediate) state:
//   - Outputs: in_ready=1, out_valid=0, frame_done=0, in_addr=0, out_addr=0, out_win=0.
//   - Pixel counter and flush counter cleared; line-buffer contents don't-care.
//   - Reset mid-frame or mid-flush aborts the frame; the next accepted pixel is index 0.
//   Input acceptance:
//   - A pixel is accepted when in_valid&&in_ready. in_addr increments by 1 per acceptance.
//   - in_valid gaps (stalls) are legal anywhere in a frame; they only delay outputs.
//   Output timing:
//   - Centre p is emitted 1 cycle after acceptance of pixel p+IMG_W+1 (registered).
//   - No output is produced for the first IMG_W+1 accepted pixels.
//   Flush (state FLUSH):
//   - Last pixel (N-1, N=IMG_W*IMG_H) accepted at cycle t.
//   - Centre N-IMG_W-2 is emitted at t+1.
//   - Centres N-IMG_W-1..N-1 are emitted on consecutive cycles t+2..t+IMG_W+2, regardless of in_valid.
//   - in_ready=0 from t+1 through t+IMG_W+2; in_valid is ignored (no pixel consumed) while in_ready=0.
//   - in_ready=1 and in_addr=0 at t+IMG_W+3; back-to-back frames are legal from then on.
//   - frame_done=1 with centre N-1.
//   FSM: IDLE (no pixel yet) -> FILL (<IMG_W+1 accepted) -> STREAM -> FLUSH -> IDLE.
//   - IDLE->FILL on first acceptance.
//   - FILL->STREAM on acceptance of pixel IMG_W.
//   - STREAM->FLUSH on acceptance of pixel N-1.
//   - FLUSH->IDLE after centre N-1.
//   Borders:
//   - Window taps outside the frame (row -1 / IMG_H, col -1 / IMG_W) are 0 when PAD_MODE=0.
//   - When PAD_MODE=1 they take the value of the clamped in-frame coordinate.
//   - Corners clamp both axes. Right-column taps must never pick up the next row's pixel (no wrap).
//   Arithmetic: data passed through bit-exact; no rounding, no sign change; -2**(DATA_W-1) preserved.
//   out_win and out_addr are held (not cleared) when out_valid=0.
// STRUCTURE
//   Package bilat_pkg:
//   - DATA_W default, PAD_ZERO/PAD_REPL constants.
//   - Window tap index constants (W_TL..W_BR = 0..8).
//   - State encoding typedef for IDLE/FILL/STREAM/FLUSH.
//   Sub-module bilat_line_buf:
//   - IMG_W-deep, DATA_W-wide delay line; one instance per buffered row (two).
//   - Shifts only on accept or flush-advance, so stalls freeze it.
//   Top:
//   - Row/col counters for input and centre, 3x3 register array, border-mux, FSM.
// TESTING (config DATA_W=9, IMG_W=4, IMG_H=3 unless noted; input = ramp 0..11)
//   1 PAD_MODE=1, continuous in_valid -> first out_valid 1 cycle after pixel 5 accepted, out_addr=0.
//     Centre 0 window = {0,0,1,0,0,1,4,4,5}; centre 11 window = {6,7,7,10,11,11,10,11,11}.
//     12 outputs total, addresses 0..11 in order, frame_done with addr 11.
//   2 PAD_MODE=0, same stimulus -> centre 0 = {0,0,0,0,0,1,0,4,5}; centre 3 = {0,0,0,2,3,0,6,7,0} (no wrap).
//   3 Random in_valid gaps (50%) -> windows/addresses identical to test 1; no out_valid without prior acceptance.
//   4 Flush: hold in_valid=1 after pixel 11 -> in_ready=0 for IMG_W+2 cycles, no extra pixel consumed.
//     Second frame of all -256 then yields all windows = nine copies of -256.
//   5 Assert rst low during pixel 7 (async, mid-cycle) -> out_valid/frame_done drop immediately, in_addr=0.
//     A fresh frame after reset matches test 1 exactly.
//   6 Default config 256x256, one frame from img1.txt.
//     -> 65536 windows; centre addresses 0..65535 in order; windows match the reference model.
//     Last output within IMG_W+3 cycles of the final input.

Source files
------------

// File: rtl/bilat_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bilat_pkg
// Description : Shared constants and types for the bilateral-filter 3x3
//               window generator.
// Revision    : 1.0 - initial release
// ============================================================================
package bilat_pkg;

   // Default pixel width (two's complement)
   localparam int DATA_W_DEF = 9;

   // Border handling modes
   localparam int PAD_ZERO = 0;
   localparam int PAD_REPL = 1;

   // Window tap indices, k = 3*row_offset + col_offset (top-left first)
   localparam int W_TL = 0;
   localparam int W_TC = 1;
   localparam int W_TR = 2;
   localparam int W_ML = 3;
   localparam int W_MC = 4;
   localparam int W_MR = 5;
   localparam int W_BL = 6;
   localparam int W_BC = 7;
   localparam int W_BR = 8;

   // Frame sequencing states
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_FILL   = 2'd1,
      ST_STREAM = 2'd2,
      ST_FLUSH  = 2'd3
   } state_t;

endpackage
`default_nettype wire

// File: rtl/bilat_line_buf.sv
`default_nettype none
// ============================================================================
// Module      : bilat_line_buf
// Description : DEPTH-entry delay line built as a circular buffer. o_dout is
//               the sample written DEPTH advances ago; it only moves on i_en.
// Revision    : 1.0 - initial release
// ============================================================================
module bilat_line_buf #(
   parameter int DATA_W = 9,
   parameter int DEPTH  = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_en,
   input  logic [DATA_W-1:0] i_din,
   output logic [DATA_W-1:0] o_dout
);

   localparam int                PTR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W-1:0]  C_PTR_LAST = PTR_W'(DEPTH - 1);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  ptr_q, ptr_d;

   // Pointer advances (with wrap) only when the stream advances
   always_comb begin
      ptr_d = ptr_q;
      if (i_en) begin
         ptr_d = (ptr_q == C_PTR_LAST) ? '0 : ptr_q + 1'b1;
      end
   end

   // Pointer register, cleared by reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   // Storage: contents are don't-care after reset, so no reset here
   always_ff @(posedge clk) begin
      if (i_en) begin
         mem_q[ptr_q] <= i_din;
      end
   end

   // Read-before-write of the slot about to be overwritten = oldest sample
   assign o_dout = mem_q[ptr_q];

endmodule
`default_nettype wire

// File: rtl/bilat_window_gen.sv
`default_nettype none
// ============================================================================
// Module      : bilat_window_gen
// Description : Raster-stream 3x3 window generator with zero or replicate
//               border padding and self-flush of the trailing rows.
// Revision    : 1.0 - initial release
// ============================================================================
module bilat_window_gen
   import bilat_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int IMG_W    = 256,
   parameter int IMG_H    = 256,
   parameter int PAD_MODE = PAD_REPL,
   parameter int ADDR_W   = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [DATA_W-1:0]   in_data,
   output logic [ADDR_W-1:0]   in_addr,
   output logic                out_valid,
   output logic [9*DATA_W-1:0] out_win,
   output logic [ADDR_W-1:0]   out_addr,
   output logic                frame_done
);

   localparam int N     = IMG_W * IMG_H;
   localparam int COL_W = $clog2(IMG_W);
   localparam int ROW_W = $clog2(IMG_H);
   localparam int FL_W  = $clog2(IMG_W + 2);

   localparam logic [ADDR_W-1:0] C_LAST     = ADDR_W'(N - 1);
   localparam logic [ADDR_W-1:0] C_FILL_END = ADDR_W'(IMG_W);
   localparam logic [FL_W-1:0]   C_FL_LAST  = FL_W'(IMG_W + 1);
   localparam logic [COL_W-1:0]  C_COL_LAST = COL_W'(IMG_W - 1);
   localparam logic [ROW_W-1:0]  C_ROW_LAST = ROW_W'(IMG_H - 1);

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   in_addr_q, in_addr_d;
   logic [ADDR_W-1:0]   cen_addr_q, cen_addr_d;
   logic [COL_W-1:0]    cen_col_q, cen_col_d;
   logic [ROW_W-1:0]    cen_row_q, cen_row_d;
   logic [FL_W-1:0]     flush_cnt_q, flush_cnt_d;
   logic                out_valid_q, out_valid_d;
   logic                frame_done_q, frame_done_d;
   logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
   logic [9*DATA_W-1:0] out_win_q, out_win_d;
   logic [DATA_W-1:0]   win_q [3][3];
   logic [DATA_W-1:0]   win_d [3][3];
   logic [DATA_W-1:0]   w_shift [3][3];

   logic                w_accept, w_flush_adv, w_advance, w_emit;
   logic [DATA_W-1:0]   w_pix, w_lb1, w_lb2;

   // One advance per accepted pixel or per flush step; flush feeds dummy
   // data whose taps are always out of frame and masked by the border mux.
   assign in_ready    = (state_q != ST_FLUSH);
   assign w_accept    = in_valid && in_ready;
   assign w_flush_adv = (state_q == ST_FLUSH) && (flush_cnt_q != C_FL_LAST);
   assign w_advance   = w_accept || w_flush_adv;
   assign w_emit      = (w_accept && (state_q == ST_STREAM)) || w_flush_adv;
   assign w_pix       = w_accept ? in_data : '0;

   // Row r-1 and row r-2 delay lines (raster index x-IMG_W and x-2*IMG_W)
   bilat_line_buf #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_lb_row1 (
      .clk    (clk),
      .rst    (rst),
      .i_en   (w_advance),
      .i_din  (w_pix),
      .o_dout (w_lb1)
   );

   bilat_line_buf #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_lb_row2 (
      .clk    (clk),
      .rst    (rst),
      .i_en   (w_advance),
      .i_din  (w_lb1),
      .o_dout (w_lb2)
   );

   // Frame sequencing and input address
   always_comb begin
      state_d     = state_q;
      in_addr_d   = in_addr_q;
      flush_cnt_d = flush_cnt_q;
      if (w_accept) begin
         in_addr_d = (in_addr_q == C_LAST) ? '0 : in_addr_q + 1'b1;
      end
      case (state_q)
         ST_IDLE: begin
            if (w_accept) state_d = ST_FILL;
         end
         ST_FILL: begin
            if (w_accept && (in_addr_q == C_FILL_END)) state_d = ST_STREAM;
         end
         ST_STREAM: begin
            if (w_accept && (in_addr_q == C_LAST)) begin
               state_d     = ST_FLUSH;
               flush_cnt_d = '0;
            end
         end
         ST_FLUSH: begin
            if (flush_cnt_q == C_FL_LAST) state_d = ST_IDLE;
            else flush_cnt_d = flush_cnt_q + 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Window shift, border mux and centre bookkeeping. Column dc of the
   // shifted array holds raster indices {y-2W, y-W, y}, which for the
   // current centre are exactly its three rows at column offset dc-1.
   always_comb begin
      logic [1:0] sr, sc;
      logic       oof;
      for (int r = 0; r < 3; r++) begin
         w_shift[r][0] = win_q[r][1];
         w_shift[r][1] = win_q[r][2];
      end
      w_shift[0][2] = w_lb2;
      w_shift[1][2] = w_lb1;
      w_shift[2][2] = w_pix;

      win_d        = w_advance ? w_shift : win_q;
      out_win_d    = out_win_q;
      out_addr_d   = out_addr_q;
      out_valid_d  = w_emit;
      frame_done_d = w_emit && (cen_addr_q == C_LAST);
      cen_addr_d   = cen_addr_q;
      cen_col_d    = cen_col_q;
      cen_row_d    = cen_row_q;

      for (int dr = 0; dr < 3; dr++) begin
         for (int dc = 0; dc < 3; dc++) begin
            sr = 2'(dr);
            sc = 2'(dc);
            if (dr == 0 && cen_row_q == '0)        sr = 2'd1;
            if (dr == 2 && cen_row_q == C_ROW_LAST) sr = 2'd1;
            if (dc == 0 && cen_col_q == '0)        sc = 2'd1;
            if (dc == 2 && cen_col_q == C_COL_LAST) sc = 2'd1;
            oof = (sr != 2'(dr)) || (sc != 2'(dc));
            if (w_emit) begin
               out_win_d[(3*dr+dc)*DATA_W +: DATA_W] =
                  (PAD_MODE == PAD_ZERO && oof) ? '0 : w_shift[sr][sc];
            end
         end
      end

      if (w_emit) begin
         out_addr_d = cen_addr_q;
         cen_addr_d = (cen_addr_q == C_LAST) ? '0 : cen_addr_q + 1'b1;
         if (cen_col_q == C_COL_LAST) begin
            cen_col_d = '0;
            cen_row_d = (cen_row_q == C_ROW_LAST) ? '0 : cen_row_q + 1'b1;
         end else begin
            cen_col_d = cen_col_q + 1'b1;
         end
      end
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         in_addr_q    <= '0;
         cen_addr_q   <= '0;
         cen_col_q    <= '0;
         cen_row_q    <= '0;
         flush_cnt_q  <= '0;
         out_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
         out_addr_q   <= '0;
         out_win_q    <= '0;
         win_q        <= '{default: '0};
      end else begin
         state_q      <= state_d;
         in_addr_q    <= in_addr_d;
         cen_addr_q   <= cen_addr_d;
         cen_col_q    <= cen_col_d;
         cen_row_q    <= cen_row_d;
         flush_cnt_q  <= flush_cnt_d;
         out_valid_q  <= out_valid_d;
         frame_done_q <= frame_done_d;
         out_addr_q   <= out_addr_d;
         out_win_q    <= out_win_d;
         win_q        <= win_d;
      end
   end

   assign in_addr    = in_addr_q;
   assign out_valid  = out_valid_q;
   assign out_win    = out_win_q;
   assign out_addr   = out_addr_q;
   assign frame_done = frame_done_q;

endmodule
`default_nettype wire
